// File: rtl/md_definitions.sv
// Shared types and constants for the RV32M multiply/divide unit.
package md_definitions;

  // Operation encoding matches funct3 of the M-extension instructions.
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  // Widest datapath the special-case constants cover; users slice to XLEN.
  localparam int MD_MAX_XLEN = 64;

  // Divide by zero returns an all-ones quotient.
  localparam logic [MD_MAX_XLEN-1:0] DIV_ZERO_QUOTIENT = '1;
  // Signed overflow (most-negative / -1) returns a zero remainder.
  localparam logic [MD_MAX_XLEN-1:0] OVF_REMAINDER     = '0;

  function automatic logic is_div_op(input md_op_t op);
    return op[2];
  endfunction

  function automatic logic is_rem_op(input md_op_t op);
    return op[2] && op[1];
  endfunction

  // rs1 is treated as signed by MUL, MULH, MULHSU, DIV and REM.
  function automatic logic op1_signed(input md_op_t op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

  // rs2 is treated as signed by MUL, MULH, DIV and REM.
  function automatic logic op2_signed(input md_op_t op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/execute_mdu_if.sv
// Execute-stage <-> multiply/divide unit handshake and result bus.
interface execute_mdu_if #(
  parameter int XLEN = 32
) ();
  import md_definitions::*;

  logic            md_valid;
  md_op_t          md_op;
  logic [XLEN-1:0] md_op1;
  logic [XLEN-1:0] md_op2;
  logic            flush;
  logic            md_stall;
  logic            md_done;
  logic [XLEN-1:0] md_result;

  // Execute stage side: issues the operation and consumes stall/result.
  modport master (
    output md_valid, md_op, md_op1, md_op2, flush,
    input  md_stall, md_done, md_result
  );

  // Unit side.
  modport slave (
    input  md_valid, md_op, md_op1, md_op2, flush,
    output md_stall, md_done, md_result
  );

endinterface

// File: rtl/md_div_step.sv
// Combinational restoring-division slice retiring UNROLL quotient bits.
module md_div_step #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // Shift the next dividend bit into the partial remainder; keep the difference when the divisor fits.
  always_comb begin
    rem_next = rem;
    quo_next = quo;
    shifted  = '0;
    trial    = '0;
    for (int i = 0; i < UNROLL; i++) begin
      shifted  = {rem_next, quo_next[XLEN-1]};
      quo_next = {quo_next[XLEN-2:0], 1'b0};
      // Partial remainder is always below the divisor, so an in-range
      // difference never sets the top bit; a borrow always does.
      trial    = shifted - {1'b0, divisor};
      if (!trial[XLEN]) begin
        rem_next    = trial[XLEN-1:0];
        quo_next[0] = 1'b1;
      end else begin
        rem_next = shifted[XLEN-1:0];
      end
    end
  end

endmodule

// File: rtl/execute_mdu.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Operands are reduced to magnitudes on accept, iterated UNROLL bits per
// cycle, and sign-corrected on the final iteration.
module execute_mdu
  import md_definitions::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input logic         clk,
  input logic         rst_n,
  execute_mdu_if.slave md
);

  localparam int ITER = XLEN / UNROLL;
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [CW-1:0] ITER_INIT = CW'(ITER);
  localparam logic [CW-1:0] CNT_LAST  = CW'(1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  if (!((UNROLL == 1) || (UNROLL == 2) || (UNROLL == 4)) || ((XLEN % UNROLL) != 0)) begin : g_bad_unroll
    $error("execute_mdu: UNROLL must be 1, 2 or 4 and divide XLEN");
  end

  function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] mag, input logic neg);
    return neg ? (~mag + 1'b1) : mag;
  endfunction

  function automatic logic [2*XLEN-1:0] apply_sign_wide(input logic [2*XLEN-1:0] mag, input logic neg);
    return neg ? (~mag + 1'b1) : mag;
  endfunction

  mdu_state_t      state;
  logic [CW-1:0]   cnt;
  md_op_t          op_q;
  logic            neg_q;
  logic [XLEN-1:0] acc_hi;    // product high half / partial remainder
  logic [XLEN-1:0] acc_lo;    // multiplier being consumed / dividend->quotient
  logic [XLEN-1:0] mcand;     // multiplicand or divisor magnitude
  logic            done_q;
  logic [XLEN-1:0] result_q;

  logic            op1_neg;
  logic            op2_neg;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic            res_neg;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] fast_result;

  // Decode the incoming operation: magnitudes, result sign and fast-path result.
  always_comb begin
    op1_neg  = op1_signed(md.md_op) && md.md_op1[XLEN-1];
    op2_neg  = op2_signed(md.md_op) && md.md_op2[XLEN-1];
    mag1     = apply_sign(md.md_op1, op1_neg);
    mag2     = apply_sign(md.md_op2, op2_neg);
    div_zero = is_div_op(md.md_op) && (md.md_op2 == '0);
    div_ovf  = is_div_op(md.md_op) && op2_signed(md.md_op) &&
               (md.md_op1 == MOST_NEG) && (md.md_op2 == '1);
    case (md.md_op)
      MD_MULHSU, MD_REM:            res_neg = op1_neg;
      MD_MULHU, MD_DIVU, MD_REMU:   res_neg = 1'b0;
      default:                      res_neg = op1_neg ^ op2_neg;
    endcase
    if (div_zero) begin
      fast_result = is_rem_op(md.md_op) ? md.md_op1 : DIV_ZERO_QUOTIENT[XLEN-1:0];
    end else begin
      fast_result = is_rem_op(md.md_op) ? OVF_REMAINDER[XLEN-1:0] : md.md_op1;
    end
  end

  logic [XLEN-1:0] mul_hi;
  logic [XLEN-1:0] mul_lo;
  logic [XLEN:0]   mul_sum;

  // Shift-add multiply: add the multiplicand when the multiplier LSB is set, then shift the pair right.
  always_comb begin
    mul_hi  = acc_hi;
    mul_lo  = acc_lo;
    mul_sum = '0;
    for (int i = 0; i < UNROLL; i++) begin
      mul_sum          = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, mcand} : '0);
      {mul_hi, mul_lo} = {mul_sum, mul_lo[XLEN-1:1]};
    end
  end

  logic [XLEN-1:0] div_rem;
  logic [XLEN-1:0] div_quo;

  md_div_step #(
    .XLEN   (XLEN),
    .UNROLL (UNROLL)
  ) u_div_step (
    .rem      (acc_hi),
    .quo      (acc_lo),
    .divisor  (mcand),
    .rem_next (div_rem),
    .quo_next (div_quo)
  );

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   final_result;

  // Sign-correct the outcome of the current iteration for the final write.
  always_comb begin
    prod = apply_sign_wide({mul_hi, mul_lo}, neg_q);
    case (op_q)
      MD_MUL:                       final_result = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: final_result = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              final_result = apply_sign(div_quo, neg_q);
      default:                      final_result = apply_sign(div_rem, neg_q);
    endcase
  end

  // Control FSM with registered done/result; flush wins over everything but reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= MD_MUL;
      neg_q    <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      mcand    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (md.flush) begin
      state  <= IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (md.md_valid) begin
            op_q   <= md.md_op;
            neg_q  <= res_neg;
            cnt    <= ITER_INIT;
            acc_hi <= '0;
            if (is_div_op(md.md_op)) begin
              acc_lo <= mag1;
              mcand  <= mag2;
            end else begin
              acc_lo <= mag2;
              mcand  <= mag1;
            end
            if (div_zero || div_ovf) begin
              result_q <= fast_result;
              done_q   <= 1'b1;
              state    <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (is_div_op(op_q)) begin
            acc_hi <= div_rem;
            acc_lo <= div_quo;
          end else begin
            acc_hi <= mul_hi;
            acc_lo <= mul_lo;
          end
          cnt <= cnt - 1'b1;
          if (cnt == CNT_LAST) begin
            result_q <= final_result;
            done_q   <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign md.md_stall  = md.md_valid && !done_q && !md.flush;
  assign md.md_done   = done_q;
  assign md.md_result = result_q;

endmodule
